// File: rtl/zest_bitslip_align_if.sv
// Bus bundle for zest_bitslip_align: start/frame in, bitslip and alignment status out.
interface zest_bitslip_align_if #(
    parameter int LANES = 8,
    parameter int DW    = 8
);
    logic             start;
    logic [DW-1:0]    frame;
    logic [LANES-1:0] bitslip;
    logic             busy;
    logic             locked;
    logic             fail;
    logic [3:0]       slip_cnt;
    logic [15:0]      err_cnt;

    modport master (
        output start, frame,
        input  bitslip, busy, locked, fail, slip_cnt, err_cnt
    );

    modport slave (
        input  start, frame,
        output bitslip, busy, locked, fail, slip_cnt, err_cnt
    );
endinterface

// File: rtl/zest_bitslip_align.sv
// Frame-pattern word aligner: slips all lanes of one AD9653 bank until the frame lane matches.
// Optional lock monitor (error count + automatic relock) enabled by `define ZEST_BITSLIP_MONITOR_EN.
module zest_bitslip_align #(
    parameter int            LANES     = 8,
    parameter int            DW        = 8,
    parameter logic [DW-1:0] FRAME_PAT = 8'hF0,
    parameter int            SETTLE    = 4,
    parameter int            CHECK_N   = 16
) (
    input logic                clk,
    input logic                rst_n,
    zest_bitslip_align_if.slave bus
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(CHECK_N - 1);
    localparam logic [3:0] SLIP_LAST   = 4'(DW - 1);

    typedef enum logic [2:0] {IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL} state_t;

    state_t           state;
    logic [LANES-1:0] bitslip_r;
    logic             busy_r;
    logic             locked_r;
    logic             fail_r;
    logic [3:0]       slip_cnt_r;
    logic [3:0]       settle_cnt;
    logic [7:0]       match_cnt;
    logic             frame_ok;
`ifdef ZEST_BITSLIP_MONITOR_EN
    logic [15:0]      err_cnt_r;
    logic [1:0]       bad_run;
`endif

    assign frame_ok = (bus.frame == FRAME_PAT);

    // Status flags are written together with the state so they track it with no extra stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitslip_r  <= '0;
            busy_r     <= 1'b0;
            locked_r   <= 1'b0;
            fail_r     <= 1'b0;
            slip_cnt_r <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
`ifdef ZEST_BITSLIP_MONITOR_EN
            err_cnt_r  <= '0;
            bad_run    <= '0;
`endif
        end else begin
            bitslip_r <= '0;
            case (state)
                IDLE, FAIL: begin
                    if (bus.start) begin
                        state      <= WAIT;
                        busy_r     <= 1'b1;
                        locked_r   <= 1'b0;
                        fail_r     <= 1'b0;
                        slip_cnt_r <= '0;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
`ifdef ZEST_BITSLIP_MONITOR_EN
                        err_cnt_r  <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (bus.start) begin
                        state      <= WAIT;
                        busy_r     <= 1'b1;
                        locked_r   <= 1'b0;
                        slip_cnt_r <= '0;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
`ifdef ZEST_BITSLIP_MONITOR_EN
                        err_cnt_r  <= '0;
                        bad_run    <= '0;
                    end else if (!frame_ok) begin
                        if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
                        // Fourth bad word in a row means alignment was lost: realign from scratch.
                        if (bad_run == 2'd3) begin
                            state      <= WAIT;
                            busy_r     <= 1'b1;
                            locked_r   <= 1'b0;
                            slip_cnt_r <= '0;
                            settle_cnt <= '0;
                            match_cnt  <= '0;
                            bad_run    <= '0;
                        end else begin
                            bad_run <= bad_run + 2'd1;
                        end
                    end else begin
                        bad_run <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        if (match_cnt == MATCH_LAST) begin
                            match_cnt <= '0;
                            state     <= LOCKED;
                            busy_r    <= 1'b0;
                            locked_r  <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end else begin
                        match_cnt <= '0;
                        // All DW phases tried once the counter reaches DW-1.
                        if (slip_cnt_r == SLIP_LAST) begin
                            state  <= FAIL;
                            busy_r <= 1'b0;
                            fail_r <= 1'b1;
                        end else begin
                            state <= SLIP;
                        end
                    end
                end
                SLIP: begin
                    bitslip_r  <= '1;
                    slip_cnt_r <= slip_cnt_r + 4'd1;
                    state      <= WAIT;
                end
                default: begin
                    state    <= IDLE;
                    busy_r   <= 1'b0;
                    locked_r <= 1'b0;
                    fail_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bitslip  = bitslip_r;
    assign bus.busy     = busy_r;
    assign bus.locked   = locked_r;
    assign bus.fail     = fail_r;
    assign bus.slip_cnt = slip_cnt_r;
`ifdef ZEST_BITSLIP_MONITOR_EN
    assign bus.err_cnt  = err_cnt_r;
`else
    assign bus.err_cnt  = '0;
`endif
endmodule

// File: tb/tb_zest_bitslip_align.sv
// Directed bench for zest_bitslip_align; a small rotation model of the deserializer supplies frame words.
module tb_zest_bitslip_align;
    logic clk;
    logic rst_n;

    zest_bitslip_align_if #(.LANES(8), .DW(8)) bus ();

    zest_bitslip_align #(
        .LANES(8), .DW(8), .FRAME_PAT(8'hF0), .SETTLE(4), .CHECK_N(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    localparam logic [7:0] PAT = 8'hF0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int phase = 0;
    bit rotate_en = 0;
    int bad_lo = -1, bad_hi = -1;
    int bad2_lo = -1, bad2_hi = -1;
    int inject_at = -1;
    int npulse = 0;
    int pulse_at [0:15];
    int at;
    bit mon;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic driveFrame();
        if ((cyc >= bad_lo && cyc <= bad_hi) || (cyc >= bad2_lo && cyc <= bad2_hi))
            bus.frame = 8'h00;
        else
            bus.frame = rotl(PAT, phase);
    endtask

    // One clock: observe outputs just after the edge, advance the lane-rotation model, drive next word.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.bitslip !== 8'h00) begin
            if (npulse < 16) pulse_at[npulse] = cyc;
            npulse++;
            checkOutput("bitslip_val", 32'(bus.bitslip), 32'hFF);
            if (rotate_en) phase = (phase + 7) % 8;
        end
        driveFrame();
    endtask

    task automatic runTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic applyStimulus();
        cyc = 0;
        npulse = 0;
        driveFrame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // sel 0: wait for locked, sel 1: wait for fail; records the first cycle it is seen.
    task automatic runUntil(input int sel, input int limit, output int seen);
        seen = -1;
        while (cyc < limit) begin
            if (sel == 0 && bus.locked === 1'b1) begin seen = cyc; break; end
            if (sel == 1 && bus.fail === 1'b1) begin seen = cyc; break; end
            if (cyc == inject_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            if (cyc == inject_at + 1) begin
                checkOutput("start_busy_slip", 32'(bus.slip_cnt), 32'd1);
                checkOutput("start_busy_busy", 32'(bus.busy), 32'd1);
            end
        end
        if (seen < 0) checkOutput("timeout", 32'd0, 32'd1);
    endtask

    initial begin
`ifdef ZEST_BITSLIP_MONITOR_EN
        mon = 1'b1;
`else
        mon = 1'b0;
`endif
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.frame = 8'h00;
        tick();
        tick();
        checkOutput("rst_bitslip", 32'(bus.bitslip), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_locked", 32'(bus.locked), 0);
        checkOutput("rst_fail", 32'(bus.fail), 0);
        checkOutput("rst_slip_cnt", 32'(bus.slip_cnt), 0);
        checkOutput("rst_err_cnt", 32'(bus.err_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Already aligned
        phase = 0; rotate_en = 1; bad_lo = -1; bad_hi = -1;
        applyStimulus();
        checkOutput("al_busy_c1", 32'(bus.busy), 1);
        runUntil(0, 100, at);
        checkOutput("al_lock_cycle", 32'(at), 21);
        checkOutput("al_slip_cnt", 32'(bus.slip_cnt), 0);
        checkOutput("al_pulses", 32'(npulse), 0);
        checkOutput("al_busy", 32'(bus.busy), 0);

        // Three phases off; restart straight from LOCKED
        phase = 3; rotate_en = 1;
        applyStimulus();
        runUntil(0, 200, at);
        checkOutput("mis_lock_cycle", 32'(at), 39);
        checkOutput("mis_pulses", 32'(npulse), 3);
        checkOutput("mis_pulse0", 32'(pulse_at[0]), 7);
        checkOutput("mis_pulse1", 32'(pulse_at[1]), 13);
        checkOutput("mis_pulse2", 32'(pulse_at[2]), 19);
        checkOutput("mis_slip_cnt", 32'(bus.slip_cnt), 3);

        // Never matching, with a start pulse while busy
        rotate_en = 0; phase = 0; bad_lo = 0; bad_hi = 100000;
        inject_at = 10;
        applyStimulus();
        runUntil(1, 300, at);
        inject_at = -1;
        checkOutput("nm_fail_cycle", 32'(at), 48);
        checkOutput("nm_pulses", 32'(npulse), 7);
        checkOutput("nm_last_pulse", 32'(pulse_at[6]), 43);
        checkOutput("nm_slip_cnt", 32'(bus.slip_cnt), 7);
        checkOutput("nm_busy", 32'(bus.busy), 0);
        checkOutput("nm_locked", 32'(bus.locked), 0);

        // One bad word after 10 matches
        bad_lo = 15; bad_hi = 15;
        applyStimulus();
        checkOutput("gl_fail_clear", 32'(bus.fail), 0);
        runUntil(0, 200, at);
        checkOutput("gl_lock_cycle", 32'(at), 37);
        checkOutput("gl_pulses", 32'(npulse), 1);
        checkOutput("gl_pulse0", 32'(pulse_at[0]), 17);
        checkOutput("gl_slip_cnt", 32'(bus.slip_cnt), 1);

        // Reset while a slip is pending, then start coincident with reset
        bad_lo = 0; bad_hi = 100000;
        applyStimulus();
        runTo(6);
        checkOutput("rs_busy_pre", 32'(bus.busy), 1);
        rst_n = 1'b0;
        tick();
        checkOutput("rs_bitslip", 32'(bus.bitslip), 0);
        checkOutput("rs_pulses", 32'(npulse), 0);
        checkOutput("rs_busy", 32'(bus.busy), 0);
        checkOutput("rs_locked", 32'(bus.locked), 0);
        checkOutput("rs_fail", 32'(bus.fail), 0);
        checkOutput("rs_slip_cnt", 32'(bus.slip_cnt), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("rs_start_ignored", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rs_still_idle", 32'(bus.busy), 0);

        // Bad words while locked
        bad_lo = 25; bad_hi = 26; bad2_lo = 30; bad2_hi = 33;
        applyStimulus();
        runUntil(0, 100, at);
        checkOutput("mn_lock_cycle", 32'(at), 21);
        runTo(28);
        checkOutput("mn_locked_2bad", 32'(bus.locked), 1);
        checkOutput("mn_err_2bad", 32'(bus.err_cnt), mon ? 32'd2 : 32'd0);
        runTo(34);
        checkOutput("mn_locked_4bad", 32'(bus.locked), mon ? 32'd0 : 32'd1);
        checkOutput("mn_busy_4bad", 32'(bus.busy), mon ? 32'd1 : 32'd0);
        runTo(54);
        checkOutput("mn_relocked", 32'(bus.locked), 1);
        checkOutput("mn_err_final", 32'(bus.err_cnt), mon ? 32'd6 : 32'd0);
        checkOutput("mn_slip_cnt", 32'(bus.slip_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
